// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control pipeline stage:
// opcodes, ALU op codes, FSM states and control bundle layout.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [2:0] OP_SHIFTI_HI = 3'b101;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_MUL   = 5'b11100;

    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_SUB  = 2'b01;
    localparam logic [1:0] F_XOR  = 2'b10;
    localparam logic [1:0] F_ANDN = 2'b11;

    localparam logic [2:0] ALU_ROL = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_ROR = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Control bundle: {passB, passA, cin, sign, invB, invA, op[2:0]}
    localparam int CTRL_W  = 9;
    localparam int B_OP_LO = 0;
    localparam int B_INVA  = 3;
    localparam int B_INVB  = 4;
    localparam int B_SIGN  = 5;
    localparam int B_CIN   = 6;
    localparam int B_PASSA = 7;
    localparam int B_PASSB = 8;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULTI  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational decoder: {op, funct} to ALU control bundle
// plus MUL / HALT / illegal classification.
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int FUNCT_W = 2
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               is_mul,
    output logic               is_halt,
    output logic               illegal
);

    logic       hi_ok;
    logic [4:0] op5;
    logic [1:0] f;

    assign op5 = op[4:0];
    assign f   = funct[1:0];

    generate
        if (OP_W > 5) begin : g_hi
            assign hi_ok = ~|op[OP_W-1:5];
        end else begin : g_nohi
            assign hi_ok = 1'b1;
        end
    endgenerate

    // Map the opcode onto the control bundle; anything unknown is illegal
    always_comb begin
        ctrl    = '0;
        is_mul  = 1'b0;
        is_halt = 1'b0;
        illegal = 1'b0;
        if (!hi_ok) begin
            illegal = 1'b1;
        end else begin
            unique casez (op5)
                OP_HALT: is_halt = 1'b1;
                OP_ALU: begin
                    unique case (f)
                        F_ADD: ctrl[B_OP_LO +: 3] = ALU_ADD;
                        F_SUB: begin
                            ctrl[B_OP_LO +: 3] = ALU_ADD;
                            ctrl[B_INVA]       = 1'b1;
                            ctrl[B_CIN]        = 1'b1;
                        end
                        F_XOR: ctrl[B_OP_LO +: 3] = ALU_XOR;
                        F_ANDN: begin
                            ctrl[B_OP_LO +: 3] = ALU_AND;
                            ctrl[B_INVA]       = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADDI: begin
                    ctrl[B_OP_LO +: 3] = ALU_ADD;
                    ctrl[B_SIGN]       = 1'b1;
                end
                OP_SUBI: begin
                    ctrl[B_OP_LO +: 3] = ALU_ADD;
                    ctrl[B_SIGN]       = 1'b1;
                    ctrl[B_INVA]       = 1'b1;
                    ctrl[B_CIN]        = 1'b1;
                end
                OP_XORI: ctrl[B_OP_LO +: 3] = ALU_XOR;
                OP_ANDNI: begin
                    ctrl[B_OP_LO +: 3] = ALU_AND;
                    ctrl[B_INVB]       = 1'b1;
                end
                OP_SHIFT: ctrl[B_OP_LO +: 3] = {1'b0, f};
                {OP_SHIFTI_HI, 2'b??}:
                    ctrl[B_OP_LO +: 3] = {1'b0, op5[1:0]};
                OP_LBI: ctrl[B_PASSB] = 1'b1;
                OP_MUL: begin
                    ctrl[B_OP_LO +: 3] = ALU_ADD;
                    is_mul             = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_pipe.sv
// ID/EX register stage for ALU control: handshake, stall/flush,
// multi-cycle MUL hold and sticky HALT.
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int FUNCT_W = 2,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic               invA,
    output logic               invB,
    output logic               sign,
    output logic               cin,
    output logic               passA,
    output logic               passB,
    output logic [2:0]         op_to_alu,
    output logic               mul_start,
    output logic               busy,
    output logic               illegal,
    output logic               halted
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_mul;
    logic              dec_halt;
    logic              dec_ill;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  cnt;
    state_t            state;
    logic              accept;

    alu_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W)
    ) u_dec (
        .op      (op),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .is_mul  (dec_mul),
        .is_halt (dec_halt),
        .illegal (dec_ill)
    );

    assign in_ready = !rst && (state == IDLE) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    assign op_to_alu = ctrl_q[B_OP_LO +: 3];
    assign invA      = ctrl_q[B_INVA];
    assign invB      = ctrl_q[B_INVB];
    assign sign      = ctrl_q[B_SIGN];
    assign cin       = ctrl_q[B_CIN];
    assign passA     = ctrl_q[B_PASSA];
    assign passB     = ctrl_q[B_PASSB];

    // Register stage, MUL countdown and IDLE/MULTI/HALTED sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            illegal   <= 1'b0;
            halted    <= 1'b0;
        end else if (flush) begin
            cnt       <= '0;
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            illegal   <= 1'b0;
            if (state != HALTED) state <= IDLE;
        end else if (!stall) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_q    <= dec_ctrl;
                        out_valid <= 1'b1;
                        illegal   <= dec_ill;
                        mul_start <= dec_mul;
                        busy      <= 1'b0;
                        if (dec_mul) begin
                            cnt <= CNT_INIT;
                            if (CNT_INIT != '0) begin
                                busy  <= 1'b1;
                                state <= MULTI;
                            end
                        end
                        if (dec_halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end
                    end else begin
                        ctrl_q    <= '0;
                        out_valid <= 1'b0;
                        illegal   <= 1'b0;
                        mul_start <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                MULTI: begin
                    mul_start <= 1'b0;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    ctrl_q    <= '0;
                    out_valid <= 1'b0;
                    illegal   <= 1'b0;
                    mul_start <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
- Registered, parametrised successor to the combinational ALU control decoder.
- Decodes {op, funct} into the ALU control bundle and registers it at the ID/EX boundary behind a valid/ready handshake, honouring stall and flush.
- Adds a multi-cycle MUL sequence with a busy counter, a sticky HALT state and an illegal-op flag.
- Sits between instruction decode and the execute-stage ALU/multiplier.

Parameters:
- OP_W, 5, opcode width. Bits above [4:0] must be zero, otherwise the op is illegal.
- FUNCT_W, 2, funct width. Only bits [1:0] are decoded.
- MUL_LAT, 4, cycles that out_valid/busy are held for MUL. Legal range is 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  block accepts this cycle
- op  in  OP_W  opcode
- funct  in  FUNCT_W  function field
- stall  in  1  execute stage cannot advance; hold all outputs
- flush  in  1  squash the registered and incoming instruction
- out_valid  out  1  registered control is valid
- invA, invB, sign, cin, passA, passB  out  1 each  ALU controls
- op_to_alu  out  3  ALU op (ROL 000, SLL 001, ROR 010, SRL 011, ADD 100, OR 101, XOR 110, AND 111)
- mul_start  out  1  one-cycle pulse that starts the multiplier
- busy  out  1  multi-cycle op in progress
- illegal  out  1  registered op was undecodable
- halted  out  1  sticky HALT seen

Behaviour:
- Reset, synchronous, rst=1 at a clk edge:
  - all outputs 0, except in_ready, which is 0 during rst and 1 after;
  - state=IDLE, cnt=0.
  - Reset mid-MUL or mid-HALT aborts to IDLE.
- Handshake:
  - in_ready = (state==IDLE) && !stall && !flush.
  - Accept = in_valid && in_ready.
  - Decoded control is visible on out_valid/controls 1 cycle after accept.
- No accept and no stall: out_valid←0 and controls←0.
- stall=1: all registered outputs and cnt hold.
- flush=1, regardless of stall:
  - out_valid, mul_start, illegal, busy and controls←0; cnt←0.
  - state←IDLE, unless state is HALTED.
  - halted is never cleared by flush.
- Decode (combinational, in the sub-module):
  - HALT 00000_xx: all controls 0.
  - ADD 11011_00: op_to_alu=100.
  - SUB 11011_01: op_to_alu=100, invA=1, cin=1.
  - XOR 11011_10: op_to_alu=110.
  - ANDN 11011_11: op_to_alu=111, invA=1.
  - ADDI 01000: op_to_alu=100, sign=1.
  - SUBI 01001: op_to_alu=100, sign=1, invA=1, cin=1.
  - XORI 01010: op_to_alu=110.
  - ANDNI 01011: op_to_alu=111, invB=1.
  - Shifts 11010_ff: op_to_alu={1'b0,ff}.
  - Immediate shifts 101ff: op_to_alu={1'b0,ff}.
  - LBI 11000: passB=1.
  - MUL 11100_xx: op_to_alu=100.
  - Anything else: controls 0, illegal=1.
- FSM:
  - IDLE, accept MUL:
    - load controls, out_valid=1, mul_start=1 for 1 cycle, cnt←MUL_LAT-1.
    - If cnt≠0, state←MULTI and busy=1.
    - MUL_LAT=1 behaves as a single-cycle op.
  - MULTI:
    - Each non-stalled cycle: cnt--, controls and out_valid held, mul_start=0.
    - When cnt reaches 0: busy←0 and state←IDLE on the same edge; out_valid drops next cycle unless a new accept occurs.
    - Total out_valid duration = MUL_LAT cycles plus stall cycles.
  - IDLE, accept HALT:
    - out_valid=1 for 1 cycle with zero controls; halted←1; state←HALTED.
  - HALTED: in_ready=0 permanently; only rst exits.
  - Illegal op: accepted normally; out_valid=1, illegal=1 for 1 cycle; state stays IDLE.
- Back-to-back single-cycle ops: in_ready stays 1 and out_valid stays continuously 1.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode/funct localparams for every instruction above;
  - op_to_alu codes;
  - FSM state encoding (IDLE, MULTI, HALTED);
  - ctrl bundle bit positions.
- Sub-module alu_decode: pure combinational {op,funct} → {ctrl bundle, is_mul, is_halt, illegal}.
- Top-level alu_control_pipe holds the register stage, counter and FSM.

Test Plan:
- Reset, then ADD (11011_00) accepted → next cycle out_valid=1, op_to_alu=100, all other controls 0.
- SUB then ADDI back-to-back → consecutive cycles show {invA=1, cin=1, 100} then {sign=1, 100}; in_ready stays 1 throughout.
- MUL with MUL_LAT=4 and stall=1 for 2 cycles mid-op:
  - mul_start pulses once;
  - busy=1 for 5 cycles;
  - out_valid=1 for 6 cycles;
  - in_ready=0 until busy falls.
- flush during MULTI → next cycle out_valid=0, busy=0, in_ready=1; LBI accepted next → passB=1.
- HALT accepted → one out_valid pulse with zero controls, halted=1; further in_valid is ignored; rst clears halted and restores in_ready=1.
- Undefined op 11111_00 → out_valid=1, illegal=1 for 1 cycle, zero controls; the following ADD decodes normally.
